// File: rtl/gcd_sched_pkg.sv
// Shared types and defaults for the round-robin GCD scheduler.
package gcd_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StIssue,
        StWait,
        StResp
    } state_e;

    localparam int unsigned DefNreq    = 4;
    localparam int unsigned DefW       = 8;
    localparam int unsigned DefTimeout = 1024;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = unsigned'($clog2(n));
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PtrW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [PtrW-1:0] win_idx_o,
    output logic            any_o
);

    // Scan NREQ slots starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned j;
        j         = 0;
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[j]) begin
                any_o       = 1'b1;
                win_oh_o[j] = 1'b1;
                win_idx_o   = PtrW'(j);
            end
        end
    end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Shares one subtractive GCD engine between NREQ requesters with round-robin
// arbitration, zero-operand bypass and a watchdog on the engine wait.
module gcd_rr_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int unsigned NREQ    = DefNreq,
    parameter int unsigned W       = DefW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] xin_bus,
    input  logic [NREQ*W-1:0] yin_bus,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rsp_vld,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_err,
    output logic            busy,
    output logic            eng_go,
    output logic [W-1:0]    eng_x,
    output logic [W-1:0]    eng_y,
    input  logic            eng_done,
    input  logic [W-1:0]    eng_r
);

    localparam int unsigned PtrW = clog2_min1(NREQ);
    localparam int unsigned CntW = clog2_min1(TIMEOUT);

    state_e          state_q;
    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] owner_q;
    logic [W-1:0]    x_q;
    logic [W-1:0]    y_q;
    logic [CntW-1:0] cnt_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] rsp_vld_q;
    logic [W-1:0]    rsp_data_q;
    logic            rsp_err_q;
    logic            busy_q;
    logic            eng_go_q;

    logic [NREQ-1:0] pick_oh;
    logic [PtrW-1:0] pick_idx;
    logic            pick_any;
    logic [W-1:0]    x_sel;
    logic [W-1:0]    y_sel;
    logic [NREQ-1:0] owner_oh;

    rr_pick #(
        .NREQ (NREQ),
        .PtrW (PtrW)
    ) u_rr_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // Select the winning requester's operand pair from the packed buses.
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == PtrW'(i)) begin
                x_sel = xin_bus[i*W +: W];
                y_sel = yin_bus[i*W +: W];
            end
        end
        owner_oh = NREQ'(1) << owner_q;
    end

    // Scheduler FSM; every output is a register loaded on entry to the state that shows it.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            eng_go_q   <= 1'b0;
        end else begin
            gnt_q     <= '0;
            rsp_vld_q <= '0;
            eng_go_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        x_q     <= x_sel;
                        y_q     <= y_sel;
                        gnt_q   <= pick_oh;
                        busy_q  <= 1'b1;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    // A zero operand would hang the subtractive engine; answer directly.
                    if (x_q == '0 || y_q == '0) begin
                        rsp_data_q <= x_q | y_q;
                        rsp_err_q  <= 1'b0;
                        rsp_vld_q  <= owner_oh;
                        state_q    <= StResp;
                    end else begin
                        eng_go_q <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // Done takes priority over a watchdog expiry in the same cycle.
                    if (eng_done) begin
                        rsp_data_q <= eng_r;
                        rsp_err_q  <= 1'b0;
                        rsp_vld_q  <= owner_oh;
                        state_q    <= StResp;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        rsp_vld_q  <= owner_oh;
                        state_q    <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    ptr_q   <= (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = busy_q;
    assign eng_go   = eng_go_q;
    assign eng_x    = x_q;
    assign eng_y    = y_q;

endmodule

// File: doc/gcd_rr_scheduler.md
Name: gcd_rr_scheduler

Overview:
- Shares one GCD engine between NREQ requesters using round-robin arbitration.
- Each accepted request is one operand pair. The block latches it, issues it to the engine, waits for the result, and returns it to the owning requester.
- Operand pairs containing zero never reach the engine, because subtractive GCD hangs on zero.
- A watchdog cycle counter catches a hung engine.
- Sits between the operand sources and the GCD datapath, below the top level that drives 7-segment display outputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand and result width.
- TIMEOUT, 1024, maximum number of WAIT cycles before the request is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until that requester's gnt.
- xin_bus  in  NREQ*W  x operands; requester i uses bits [i*W +: W].
- yin_bus  in  NREQ*W  y operands; same packing as xin_bus.
- gnt  out  NREQ  one-hot acceptance pulse, 1 cycle.
- rsp_vld  out  NREQ  one-hot result-valid pulse, 1 cycle.
- rsp_data  out  W  result; valid when any rsp_vld bit is high.
- rsp_err  out  1  timeout flag; qualified by rsp_vld.
- busy  out  1  high in every state except IDLE.
- eng_go  out  1  engine start pulse, 1 cycle.
- eng_x  out  W  engine x operand; stable from ISSUE through the end of WAIT.
- eng_y  out  W  engine y operand; stable from ISSUE through the end of WAIT.
- eng_done  in  1  engine completion pulse.
- eng_r  in  W  engine result; valid while eng_done is high.

Behaviour:
- All outputs are registered.
- clr (synchronous, active-high) forces: state=IDLE, round-robin pointer=0, watchdog counter=0, all outputs 0, latched operands 0.
- clr mid-operation discards the in-flight request with no response.
- States: IDLE, GRANT, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, pick the first set bit at or after the pointer, wrapping modulo NREQ.
  - Latch owner, x and y.
  - Go to GRANT.
- GRANT:
  - gnt[owner]=1 for this cycle.
  - If x==0 or y==0: result = x|y (so 0,0 gives 0), go to RESP; eng_go is never raised.
  - Otherwise go to ISSUE.
- ISSUE:
  - eng_go=1 for this cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT:
  - On eng_done: capture eng_r, rsp_err=0, go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT-1 without eng_done: result=0, rsp_err=1, go to RESP.
  - If eng_done coincides with the timeout cycle, done wins and rsp_err=0.
- RESP:
  - rsp_vld[owner]=1 with rsp_data and rsp_err for this cycle.
  - pointer = (owner+1) mod NREQ.
  - Go to IDLE.
- eng_done is sampled only in WAIT and ignored in every other state, including a late done after a timeout.
- Latency, normal path: request sampled in IDLE at edge k gives gnt during cycle k+1 and eng_go during k+2. rsp_vld follows the cycle after eng_done.
- Latency, zero-operand path: rsp_vld during k+2.
- rsp_data and rsp_err are held at their value outside RESP; the bench checks them only with rsp_vld.
- A requester whose req stays high after its gnt is treated as a new request. It is re-arbitrated on the next visit to IDLE.
- Operands on the buses are sampled only in IDLE. Later bus changes do not affect the in-flight request.
- Minimum period between back-to-back requests: 5 cycles through the engine path, 3 cycles through the zero-operand path.

Decomposition:
- Package gcd_sched_pkg:
  - state enum (IDLE, GRANT, ISSUE, WAIT, RESP);
  - default W/NREQ/TIMEOUT localparams;
  - helper function for the clog2 width of the pointer and counter.
- Sub-module rr_pick: purely combinational. Inputs: req vector and pointer. Outputs: one-hot winner, winner index, any flag.
- The scheduler holds the FSM, operand latches, watchdog counter and output registers.

Test Plan:
- Requester 0 only, x=228, y=52; engine model returns 4 after 40 cycles → gnt=0001, one eng_go with eng_x=228/eng_y=52, then rsp_vld=0001, rsp_data=4, rsp_err=0.
- After clr, req=0111 simultaneously with pairs (52,52), (45,139), (228,52) → grants in order 0, 1, 2; responses 52, 1, 4 with matching rsp_vld bits.
- Fairness: serve requester 1, then raise req=0101 → requester 2 is granted before 0; the pointer ends at 1 after 0 is served.
- Zero operands: requester 3 with x=0, y=139 → rsp_data=139 two cycles after IDLE sampling; (0,0) → rsp_data=0; eng_go stays 0 in both cases.
- Timeout with TIMEOUT=16: engine never asserts done → rsp_err=1, rsp_data=0 exactly 16 WAIT cycles after eng_go. A later spurious eng_done in IDLE produces no response.
- Assert clr in WAIT → next cycle all outputs are 0 and busy=0, and no rsp_vld appears. A fresh request from requester 3 is granted ahead of 0–2 only if they are idle, since the pointer restarts at 0.
